spi_target: RTL and testbench

SPI responder (target) for the peripheral side of our SPI links. It receives frames of 1 to MAX_BYTES bytes from an `SPIController` initiator and returns a preloaded response on CIPO. It supports all four CPOL/CPHA modes. The SPI pins are oversampled in the `clk` domain, so no second clock domain exists. It sits behind a chip-select line and serves as the bench partner for controller verification and as the front end of register-mapped peripherals.

---
 rtl/spi_target_if.sv | 32 +++
 rtl/spi_target.sv | 183 ++++++++++++++++++
 tb/tb_spi_target.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/spi_target_if.sv
// SPI target pin and result bundle: initiator-side pins plus the parallel
// response/result word seen by the host logic.
interface spi_target_if #(
  parameter int unsigned MAX_BYTES = 4
) ();
  localparam int unsigned RXBW = $clog2(MAX_BYTES + 1);

  logic                       CPOL;
  logic                       CPHA;
  logic                       CS_n;
  logic                       PCLK;
  logic                       COPI;
  logic                       CIPO;
  logic                       CIPO_OE;
  logic [MAX_BYTES-1:0][7:0]  D_TX;
  logic [MAX_BYTES-1:0][7:0]  Q_RX;
  logic [RXBW-1:0]            RX_BYTES;
  logic                       BUSY;
  logic                       DONE;
  logic                       FRAME_ERR;
  logic                       OVERFLOW;

  modport slave (
    input  CPOL, CPHA, CS_n, PCLK, COPI, D_TX,
    output CIPO, CIPO_OE, Q_RX, RX_BYTES, BUSY, DONE, FRAME_ERR, OVERFLOW
  );

  modport master (
    output CPOL, CPHA, CS_n, PCLK, COPI, D_TX,
    input  CIPO, CIPO_OE, Q_RX, RX_BYTES, BUSY, DONE, FRAME_ERR, OVERFLOW
  );
endinterface

// File: rtl/spi_target.sv
// SPI target with oversampled pins: receives 1..MAX_BYTES byte frames on COPI
// and returns a response latched at frame start on CIPO, all four CPOL/CPHA modes.
module spi_target #(
  parameter int unsigned MAX_BYTES   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  spi_target_if.slave bus
);

  localparam int unsigned NBITS = MAX_BYTES * 8;
  localparam int unsigned CNTW  = $clog2(NBITS + 2);
  localparam int unsigned RXBW  = $clog2(MAX_BYTES + 1);
  localparam int unsigned CH    = SYNC_STAGES + 2;

  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(NBITS);
  localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(NBITS + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, FINISH} state_e;

  // Synchronizer chains; the top two CS/PCLK stages form the edge-detect pair.
  logic [CH-1:0] cs_ch_q, pclk_ch_q, vld_q;
  logic [CH-2:0] copi_ch_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_ch_q   <= '1;
      pclk_ch_q <= '0;
      copi_ch_q <= '0;
      vld_q     <= '0;
    end else begin
      cs_ch_q   <= {cs_ch_q[CH-2:0], bus.CS_n};
      pclk_ch_q <= {pclk_ch_q[CH-2:0], bus.PCLK};
      copi_ch_q <= {copi_ch_q[CH-3:0], bus.COPI};
      vld_q     <= {vld_q[CH-2:0], 1'b1};
    end
  end

  logic cs_cur, cs_prev, pclk_cur, pclk_prev, copi_cur;
  assign cs_cur    = cs_ch_q[CH-2];
  assign cs_prev   = cs_ch_q[CH-1];
  assign pclk_cur  = pclk_ch_q[CH-2];
  assign pclk_prev = pclk_ch_q[CH-1];
  assign copi_cur  = copi_ch_q[CH-2];

  state_e            state_q, state_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d;
  logic [NBITS-1:0]  tx_q, tx_d, rx_q, rx_d, q_rx_q, q_rx_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [2:0]        ph_q, ph_d;
  logic              cipo_q, cipo_d, oe_q, oe_d, busy_q, busy_d, done_q, done_d;
  logic              ferr_q, ferr_d, ovf_q, ovf_d;
  logic [RXBW-1:0]   rx_bytes_q, rx_bytes_d;

  logic [NBITS-1:0]  d_tx_c;
  logic              lead_c, trail_c, sample_c, shift_c, cs_fall_c, cs_rise_c;

  assign d_tx_c = bus.D_TX;

  // A CS fall only counts once a genuine high sample has reached the compare stage.
  assign cs_fall_c = vld_q[CH-1] & cs_prev & ~cs_cur;
  assign cs_rise_c = ~cs_prev & cs_cur;
  assign lead_c    = (pclk_prev == cpol_q) && (pclk_cur != cpol_q);
  assign trail_c   = (pclk_prev != cpol_q) && (pclk_cur == cpol_q);
  assign sample_c  = cpha_q ? trail_c : lead_c;
  assign shift_c   = cpha_q ? lead_c : trail_c;

  always_comb begin
    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    q_rx_d     = q_rx_q;
    cnt_d      = cnt_q;
    ph_d       = ph_q;
    cipo_d     = cipo_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ferr_d     = ferr_q;
    ovf_d      = ovf_q;
    rx_bytes_d = rx_bytes_q;

    unique case (state_q)
      IDLE: begin
        if (cs_fall_c) begin
          state_d = ACTIVE;
          cpol_d  = bus.CPOL;
          cpha_d  = bus.CPHA;
          rx_d    = '0;
          cnt_d   = '0;
          ph_d    = '0;
          busy_d  = 1'b1;
          oe_d    = 1'b1;
          // CPHA=0 needs the first bit on the wire before the first leading edge.
          if (bus.CPHA) begin
            tx_d   = d_tx_c;
            cipo_d = 1'b0;
          end else begin
            tx_d   = {d_tx_c[NBITS-2:0], 1'b0};
            cipo_d = d_tx_c[NBITS-1];
          end
        end
      end

      ACTIVE: begin
        if (cs_rise_c) begin
          state_d    = FINISH;
          q_rx_d     = rx_q;
          rx_bytes_d = (cnt_q >= CNT_FULL) ? RXBW'(MAX_BYTES) : RXBW'(cnt_q >> 3);
          ferr_d     = (ph_q != 3'd0);
          ovf_d      = (cnt_q > CNT_FULL);
          done_d     = 1'b1;
          busy_d     = 1'b0;
          oe_d       = 1'b0;
          cipo_d     = 1'b0;
        end else begin
          if (sample_c) begin
            rx_d = {rx_q[NBITS-2:0], copi_cur};
            ph_d = ph_q + 3'd1;
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNTW'(1);
          end
          if (shift_c) begin
            cipo_d = tx_q[NBITS-1];
            tx_d   = {tx_q[NBITS-2:0], 1'b0};
          end
        end
      end

      FINISH: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      q_rx_q     <= '0;
      cnt_q      <= '0;
      ph_q       <= '0;
      cipo_q     <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rx_bytes_q <= '0;
    end else begin
      state_q    <= state_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      q_rx_q     <= q_rx_d;
      cnt_q      <= cnt_d;
      ph_q       <= ph_d;
      cipo_q     <= cipo_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
      rx_bytes_q <= rx_bytes_d;
    end
  end

  assign bus.CIPO      = cipo_q;
  assign bus.CIPO_OE   = oe_q;
  assign bus.Q_RX      = q_rx_q;
  assign bus.RX_BYTES  = rx_bytes_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.FRAME_ERR = ferr_q;
  assign bus.OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: acts as the SPI initiator and checks each frame against
// a frame-level model of what the target must return and report.
module tb_spi_target;

  localparam int unsigned MB = 4;
  localparam int unsigned H  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_target_if #(.MAX_BYTES(MB)) bus ();
  spi_target #(.MAX_BYTES(MB), .SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;

  always @(negedge clk) if (bus.DONE === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic half();
    repeat (H) @(negedge clk);
  endtask

  // One complete frame of n bits; copi holds the bits right-justified, MSB sent first.
  task automatic run_frame(input bit cpol, input bit cpha, input int n,
                           input logic [63:0] copi, input logic [31:0] dtx,
                           input bit flip);
    logic [63:0] got_cipo, exp_cipo, exp_q;
    int d0, t, rb;
    bus.CPOL = cpol; bus.CPHA = cpha; bus.PCLK = cpol; bus.COPI = 1'b0;
    bus.D_TX = dtx;
    half();
    chk("oe_idle", 64'(bus.CIPO_OE), 64'd0);
    d0 = done_cnt;
    if (n > 0 && !cpha) bus.COPI = copi[n-1];
    bus.CS_n = 1'b0;
    half();
    chk("busy_start", 64'(bus.BUSY), 64'd1);
    got_cipo = '0;
    for (int i = 0; i < n; i++) begin
      if (flip && i == n / 2) begin
        bus.CPOL = ~bus.CPOL;
        bus.CPHA = ~bus.CPHA;
        bus.D_TX = ~dtx;
      end
      if (cpha) begin
        bus.PCLK = ~cpol; bus.COPI = copi[n-1-i];
        half();
        got_cipo = {got_cipo[62:0], bus.CIPO};
        bus.PCLK = cpol;
        half();
      end else begin
        got_cipo = {got_cipo[62:0], bus.CIPO};
        bus.PCLK = ~cpol;
        half();
        bus.PCLK = cpol;
        if (i + 1 < n) bus.COPI = copi[n-2-i];
        half();
      end
    end
    bus.CS_n = 1'b1;
    t = 0;
    while (bus.DONE !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 64'(bus.DONE), 64'd1);
    exp_q = (n >= 32) ? {32'd0, copi[31:0]} : (copi & ((64'd1 << n) - 64'd1));
    rb = (n / 8 > int'(MB)) ? int'(MB) : n / 8;
    chk("q_rx", 64'(bus.Q_RX), exp_q);
    chk("rx_bytes", 64'(bus.RX_BYTES), 64'(rb));
    chk("frame_err", 64'(bus.FRAME_ERR), 64'((n % 8) != 0));
    chk("overflow", 64'(bus.OVERFLOW), 64'(n > 32));
    chk("busy_end", 64'(bus.BUSY), 64'd0);
    if (n > 0) begin
      exp_cipo = ({32'd0, dtx} << 32) >> (64 - n);
      chk("cipo", got_cipo, exp_cipo);
    end
    repeat (3) @(negedge clk);
    chk("done_once", 64'(done_cnt - d0), 64'd1);
    chk("oe_after", 64'(bus.CIPO_OE), 64'd0);
  endtask

  initial begin
    logic [63:0] rc;
    int d0;
    bus.CS_n = 1'b1; bus.PCLK = 1'b0; bus.COPI = 1'b0;
    bus.CPOL = 1'b0; bus.CPHA = 1'b0; bus.D_TX = '0;
    repeat (3) @(negedge clk);
    chk("rst_q_rx", 64'(bus.Q_RX), 64'd0);
    chk("rst_rx_bytes", 64'(bus.RX_BYTES), 64'd0);
    chk("rst_busy", 64'(bus.BUSY), 64'd0);
    chk("rst_done", 64'(bus.DONE), 64'd0);
    chk("rst_oe", 64'(bus.CIPO_OE), 64'd0);
    chk("rst_cipo", 64'(bus.CIPO), 64'd0);
    chk("rst_flags", {62'd0, bus.FRAME_ERR, bus.OVERFLOW}, 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    run_frame(1'b0, 1'b0, 8,  64'hAC,   32'hDE5A_A5C3, 1'b0);
    run_frame(1'b0, 1'b1, 16, 64'hDEAD, 32'h1234_5678, 1'b0);
    run_frame(1'b1, 1'b1, 32, 64'h89AB_CDEF, 32'hCAFE_F00D, 1'b0);
    run_frame(1'b0, 1'b0, 12, 64'hABC, 32'h0F0F_1234, 1'b0);
    run_frame(1'b1, 1'b0, 40, 64'h11_2233_4455, 32'h8765_4321, 1'b0);
    run_frame(1'b0, 1'b0, 0,  64'h0, 32'hFFFF_FFFF, 1'b0);
    run_frame(1'b0, 1'b1, 24, 64'hC0FFEE, 32'hA1B2_C3D4, 1'b1);
    run_frame(1'b1, 1'b0, 16, 64'h5AA5, 32'h3C3C_9999, 1'b1);

    // Reset mid-frame after 5 bits must clear everything and yield no DONE.
    bus.CPOL = 1'b0; bus.CPHA = 1'b0; bus.PCLK = 1'b0; bus.COPI = 1'b1;
    half();
    d0 = done_cnt;
    bus.CS_n = 1'b0;
    half();
    for (int i = 0; i < 5; i++) begin
      bus.PCLK = 1'b1; half(); bus.PCLK = 1'b0; half();
    end
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_q_rx", 64'(bus.Q_RX), 64'd0);
    chk("mid_rst_busy_oe", {62'd0, bus.BUSY, bus.CIPO_OE}, 64'd0);
    chk("mid_rst_misc", {59'd0, bus.RX_BYTES, bus.DONE, bus.FRAME_ERR}, 64'd0);
    // Release reset with CS still low: no frame may start from that stale select.
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    half();
    for (int i = 0; i < 4; i++) begin
      bus.PCLK = 1'b1; half(); bus.PCLK = 1'b0; half();
    end
    chk("no_frame_busy", 64'(bus.BUSY), 64'd0);
    bus.CS_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_done_after_rst", 64'(done_cnt - d0), 64'd0);
    chk("no_frame_q_rx", 64'(bus.Q_RX), 64'd0);

    for (int k = 0; k < 24; k++) begin
      rc = {$urandom, $urandom};
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 40)), rc, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
